// File: rtl/mem_access_stage_pkg.sv
// ============================================================================
// Module : mem_access_stage_pkg
// Brief  : Shared types, funct3 encodings and lane helpers for the MEM stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_access_stage_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_PC4  = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     rd_data2;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]                funct3;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic                      MemWrite;
    logic                      MemRead;
    logic                      RegWrite;
    wb_sel_e                   WBSel;
  } pipe_ex2mem_t;

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      RegWrite;
    wb_sel_e                   WBSel;
  } pipe_mem2wb_t;

  // Subset of EX2MEM kept alive while a transaction is outstanding.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]                funct3;
    logic                      is_store;
    logic                      RegWrite;
    wb_sel_e                   WBSel;
  } mem_req_t;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Shifting inside a 4-bit mask naturally drops lanes past byte 3.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [2:0] f3,
                                                     input logic [DATA_WIDTH-1:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_load_formatter.sv
// ============================================================================
// Module : mem_access_stage_load_formatter
// Brief  : Aligns a loaded word to its byte offset and sign/zero-extends it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_stage_load_formatter
  import mem_access_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            off,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = word >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module : mem_access_stage
// Brief  : Pipeline MEM stage; drives a req/gnt/rvalid data port and a
//          registered MEM2WB bundle. Optional macro: MEM_MISALIGN_TRAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  pipe_ex2mem_t          bus_in,
  output pipe_mem2wb_t          bus_out,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_fault
`endif
);

  mem_state_e            state, state_nxt;
  mem_req_t              req_q;
  logic [DATA_WIDTH-1:0] load_data;
  logic [1:0]            off;
  logic                  mem_op;
  logic                  accept_mem;

  assign off    = bus_in.alu_result[1:0];
  assign mem_op = bus_in.valid && (bus_in.MemRead || bus_in.MemWrite);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = is_misaligned(bus_in.funct3, off);
  assign accept_mem = mem_op && !misaligned;
`else
  assign accept_mem = mem_op;
`endif

  function automatic pipe_mem2wb_t wb_pass(input pipe_ex2mem_t s, input logic keep_rw);
    pipe_mem2wb_t w;
    w.valid      = 1'b1;
    w.alu_result = s.alu_result;
    w.mem_rdata  = '0;
    w.pc_plus4   = s.pc_plus4;
    w.rd_addr    = s.rd_addr;
    w.RegWrite   = s.RegWrite & keep_rw;
    w.WBSel      = s.WBSel;
    return w;
  endfunction

  function automatic pipe_mem2wb_t wb_done(input mem_req_t r, input logic [DATA_WIDTH-1:0] rd);
    pipe_mem2wb_t w;
    w.valid      = 1'b1;
    w.alu_result = r.alu_result;
    w.mem_rdata  = rd;
    w.pc_plus4   = r.pc_plus4;
    w.rd_addr    = r.rd_addr;
    w.RegWrite   = r.RegWrite & ~r.is_store;
    w.WBSel      = r.WBSel;
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: if (accept_mem) state_nxt = MEM_REQ;
      MEM_REQ:  if (dmem_gnt)   state_nxt = req_q.is_store ? MEM_IDLE : MEM_WAIT;
      MEM_WAIT: if (dmem_rvalid) state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = (state != MEM_IDLE);
    dmem_req  = (state == MEM_REQ);
    dmem_we   = (state == MEM_REQ) && req_q.is_store;
  end

  // Request registers: loaded once on acceptance, frozen for the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else if (state == MEM_IDLE && accept_mem) begin
      req_q.alu_result <= bus_in.alu_result;
      req_q.pc_plus4   <= bus_in.pc_plus4;
      req_q.rd_addr    <= bus_in.rd_addr;
      req_q.funct3     <= bus_in.funct3;
      req_q.is_store   <= bus_in.MemWrite;
      req_q.RegWrite   <= bus_in.RegWrite;
      req_q.WBSel      <= bus_in.WBSel;
      dmem_addr        <= {bus_in.alu_result[DATA_WIDTH-1:2], 2'b00};
      dmem_be          <= lane_mask(bus_in.funct3, off);
      dmem_wdata       <= lane_data(bus_in.funct3, bus_in.rd_data2);
    end
  end

  mem_access_stage_load_formatter u_load_formatter (
    .word   (dmem_rdata),
    .off    (req_q.alu_result[1:0]),
    .funct3 (req_q.funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out <= '0;
    end else begin
      bus_out.valid <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (bus_in.valid && !mem_op) bus_out <= wb_pass(bus_in, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
          else if (mem_op && misaligned) bus_out <= wb_pass(bus_in, 1'b0);
`endif
        end
        MEM_REQ:  if (dmem_gnt && req_q.is_store) bus_out <= wb_done(req_q, '0);
        MEM_WAIT: if (dmem_rvalid) bus_out <= wb_done(req_q, load_data);
        default:  ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_fault <= 1'b0;
    else        misalign_fault <= (state == MEM_IDLE) && mem_op && misaligned;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Directed self-checking bench for mem_access_stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  pipe_ex2mem_t bus_in;
  pipe_mem2wb_t bus_out;
  logic         mem_stall, dmem_req, dmem_we;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]   dmem_be;
  logic         dmem_gnt, dmem_rvalid;
`ifdef MEM_MISALIGN_TRAP_EN
  logic         misalign_fault;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, hold_ok;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .mem_stall   (mem_stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_fault (misalign_fault)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic pipe_ex2mem_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] alu, input logic [31:0] d2);
    pipe_ex2mem_t p;
    p = '0;
    p.valid      = 1'b1;
    p.alu_result = alu;
    p.rd_data2   = d2;
    p.rd_addr    = 5'd7;
    p.funct3     = f3;
    p.pc_plus4   = 32'h0000_0404;
    p.MemRead    = rd;
    p.MemWrite   = wr;
    p.RegWrite   = !wr;
    p.WBSel      = rd ? WB_MEM : WB_ALU;
    return p;
  endfunction

  // Holds bus_in for the whole transaction; gnt after gw REQ cycles, rvalid after rw WAIT cycles.
  task automatic run_mem(input pipe_ex2mem_t op, input int gw, input int rw, input logic [31:0] rd);
    bus_in = op;
    step();
    cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata; cap_we = dmem_we;
    hold_ok = 1'b1;
    for (int i = 0; i < gw; i++) begin
      if (!dmem_req || !mem_stall || bus_out.valid) hold_ok = 1'b0;
      step();
    end
    if (!dmem_req || !mem_stall || bus_out.valid) hold_ok = 1'b0;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    if (!op.MemWrite) begin
      for (int i = 0; i <= rw; i++) begin
        if (dmem_req || !mem_stall || bus_out.valid) hold_ok = 1'b0;
        if (i == rw) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rd;
        end
        step();
      end
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
    end
    bus_in = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_in = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) step();
    check("reset bus_out", bus_out, 128'h0);
    check("reset req/we/stall", {dmem_req, dmem_we, mem_stall}, 3'b000);
    check("reset addr/be/wdata", {dmem_addr, dmem_be, dmem_wdata}, 68'h0);
    rst_n = 1'b1;

    // Non-memory op, with a stray gnt that IDLE must ignore.
    bus_in = mk(1'b0, 1'b0, 3'b000, 32'h0000_012C, 32'h0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    bus_in = '0;
    check("alu pass valid/rw", {bus_out.valid, bus_out.RegWrite}, 2'b11);
    check("alu pass result", bus_out.alu_result, 32'h12C);
    check("alu pass rdata", bus_out.mem_rdata, 32'h0);
    check("alu no req/stall", {dmem_req, mem_stall}, 2'b00);
    step();
    check("alu bubble after", bus_out.valid, 1'b0);

    run_mem(mk(1'b0, 1'b1, F3_W, 32'h0000_07D0, 32'hCAFE_CAFE), 1, 0, 32'h0);
    check("sw be", cap_be, 4'hF);
    check("sw wdata", cap_wdata, 32'hCAFE_CAFE);
    check("sw addr/we", {cap_addr, cap_we}, {32'h7D0, 1'b1});
    check("sw stall held", hold_ok, 1'b1);
    check("sw out valid/rw", {bus_out.valid, bus_out.RegWrite}, 2'b10);
    check("sw done stall", {dmem_req, mem_stall}, 2'b00);

    run_mem(mk(1'b0, 1'b1, F3_B, 32'h0000_1003, 32'h0000_00A5), 0, 0, 32'h0);
    check("sb be", cap_be, 4'b1000);
    check("sb wdata", cap_wdata, 32'hA5A5_A5A5);
    check("sb addr", cap_addr, 32'h1000);

    run_mem(mk(1'b0, 1'b1, F3_H, 32'h0000_1002, 32'h1234_BEEF), 0, 0, 32'h0);
    check("sh be/wdata", {cap_be, cap_wdata}, {4'b1100, 32'hBEEF_BEEF});

    run_mem(mk(1'b1, 1'b0, F3_B, 32'h0000_1002, 32'h0), 0, 0, 32'h0080_0000);
    check("lb rdata", bus_out.mem_rdata, 32'hFFFF_FF80);
    check("lb ctrl", {bus_out.valid, bus_out.RegWrite, bus_out.WBSel, bus_out.rd_addr},
          {1'b1, 1'b1, WB_MEM, 5'd7});
    check("lb hold", hold_ok, 1'b1);
    run_mem(mk(1'b1, 1'b0, F3_BU, 32'h0000_1002, 32'h0), 1, 1, 32'h0080_0000);
    check("lbu rdata", bus_out.mem_rdata, 32'h0000_0080);
    run_mem(mk(1'b1, 1'b0, F3_H, 32'h0000_1002, 32'h0), 0, 0, 32'h8001_0000);
    check("lh rdata", bus_out.mem_rdata, 32'hFFFF_8001);
    run_mem(mk(1'b1, 1'b0, F3_HU, 32'h0000_1000, 32'h0), 0, 0, 32'h1234_8001);
    check("lhu rdata", bus_out.mem_rdata, 32'h0000_8001);
    run_mem(mk(1'b1, 1'b0, F3_W, 32'h0000_1004, 32'h0), 2, 2, 32'hDEAD_BEEF);
    check("lw rdata/addr", {bus_out.mem_rdata, cap_addr}, {32'hDEAD_BEEF, 32'h1004});
    check("lw hold", hold_ok, 1'b1);

    // Load abandoned by reset while waiting for rvalid.
    bus_in = mk(1'b1, 1'b0, F3_W, 32'h0000_2000, 32'h0);
    step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    repeat (4) step();
    check("wait stall", {mem_stall, dmem_req}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("async rst req/stall", {dmem_req, mem_stall, dmem_we}, 3'b000);
    check("async rst bus_out", bus_out, 128'h0);
    bus_in = '0;
    step();
    rst_n = 1'b1;
    step();
    check("post rst idle", {mem_stall, dmem_req, bus_out.valid}, 3'b000);

`ifdef MEM_MISALIGN_TRAP_EN
    bus_in = mk(1'b1, 1'b0, F3_W, 32'h0000_1001, 32'h0);
    step();
    bus_in = '0;
    check("trap no req/stall", {dmem_req, mem_stall}, 2'b00);
    check("trap fault", misalign_fault, 1'b1);
    check("trap out valid/rw", {bus_out.valid, bus_out.RegWrite}, 2'b10);
    step();
    check("trap fault pulse", misalign_fault, 1'b0);
`else
    run_mem(mk(1'b0, 1'b1, F3_H, 32'h0000_1003, 32'h0000_5A3C), 0, 0, 32'h0);
    check("sh misalign be", {cap_be, cap_wdata, cap_addr}, {4'b1000, 32'h5A3C_5A3C, 32'h1000});
    run_mem(mk(1'b1, 1'b0, F3_H, 32'h0000_1003, 32'h0), 0, 0, 32'h80FF_FFFF);
    check("lh misalign rdata", bus_out.mem_rdata, 32'h0000_0080);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage core. Sits directly downstream of `EX_stage`:
- consumes the EX2MEM bundle (ALU result as address, store data, control);
- performs the data-memory transaction through a request/grant/response port;
- formats load data and drives a registered MEM2WB bundle.

Holds the pipeline via `mem_stall` while a transaction is outstanding.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data/address width (from `core_pkg`)
- `REG_ADDR_WIDTH`, 5, register index width (from `core_pkg`)

Ports:
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `bus_in`  `EX2MEM_if.SLAVE`  –  fields `valid`, `alu_result`, `rd_data2`, `rd_addr`, `funct3`, `pc_plus4`, `MemWrite`, `MemRead`, `RegWrite`, `WBSel`
- `bus_out`  `MEM2WB_if.MASTER`  –  fields `valid`, `alu_result`, `mem_rdata`, `pc_plus4`, `rd_addr`, `RegWrite`, `WBSel` (registered)
- `mem_stall`  out  1  upstream must hold `bus_in` stable while high
- `dmem_req`  out  1  transaction request, held until `dmem_gnt`
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  word-aligned address (`[1:0]` = 0)
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_gnt`  in  1  request accepted this cycle
- `dmem_rvalid`  in  1  load data valid (at least 1 cycle after `dmem_gnt`)
- `dmem_rdata`  in  32  load data word
- `misalign_fault`  out  1  one-cycle pulse, only present with `MEM_MISALIGN_TRAP_EN`

## Operation
FSM states: IDLE, REQ, WAIT.

IDLE:
- `bus_in.valid` with neither MemRead nor MemWrite: pass through to `bus_out` at next edge; `mem_rdata` = 0.
- MemRead or MemWrite: capture address, `be`, `wdata`, `funct3` and control into request registers; go to REQ; drive `bus_out.valid` = 0 next cycle (bubble).

REQ:
- `dmem_req` = 1; address, `we`, `be`, `wdata` held constant.
- On `dmem_gnt`: store goes to IDLE and drives `bus_out.valid` = 1 at that edge; load goes to WAIT.

WAIT:
- On `dmem_rvalid`: format `dmem_rdata`, drive `bus_out` at that edge, go to IDLE.

`mem_stall` = (state != IDLE). In IDLE, the current `bus_in` is always accepted.

Byte lane from `alu_result[1:0]`:
- SB: `be` = 0001 << off, `wdata` = {4{byte}}
- SH: `be` = 0011 << off, `wdata` = {2{half}}
- SW: `be` = 1111
- Loads shift the word right by 8×off, then:
  - LB, LH: sign-extend
  - LBU, LHU: zero-extend
  - LW: pass unchanged

Misaligned access: SH/LH/LHU with off[0] = 1, or SW/LW with off ≠ 0. Handling per Configuration.

Stores: `bus_out.RegWrite` = 0 regardless of input.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we` 0; `dmem_addr`, `dmem_be`, `dmem_wdata` 0; `bus_out` all fields 0 (`WBSel` = `WB_NONE`); `misalign_fault` 0; `mem_stall` 0.
- Non-memory op latency: 1 cycle.
- Store: `bus_out` valid 1 cycle after the `dmem_gnt` cycle; minimum 2 cycles.
- Load: `bus_out` valid 1 cycle after the `dmem_rvalid` cycle; minimum 3 cycles.
- `dmem_gnt` and `dmem_rvalid` are ignored in IDLE. `dmem_rvalid` in REQ is ignored.
- Reset asserted mid-transaction: all outputs return to reset values immediately; the outstanding request is abandoned.

## Configuration
`MEM_MISALIGN_TRAP_EN`:
- Defined: misaligned access issues no request and stays in IDLE. `misalign_fault` pulses 1 cycle. `bus_out.valid` = 1 with `RegWrite` = 0.
- Undefined: port absent; the access proceeds with lane masks truncated to the 4-byte word (bytes beyond `[3]` dropped).

## Structure
- `core_pkg` additions:
  - `mem_state_e` {`MEM_IDLE`, `MEM_REQ`, `MEM_WAIT`}
  - `funct3` load/store encodings
  - `pipe_ex2mem_t` and `pipe_mem2wb_t` struct updates
- One sub-module: `load_formatter` (combinational shift plus sign/zero extension).

## Test plan
- ADD result 0x12C, no memory op → `bus_out.alu_result` = 0x12C one cycle later, `dmem_req` never asserted.
- SW 0xCAFECAFE to 0x7D0, `dmem_gnt` after 2 cycles → `be` = 1111, `wdata` = 0xCAFECAFE, `mem_stall` high throughout, `RegWrite` out = 0.
- SB 0x000000A5 to 0x1003 → `be` = 1000, `wdata` = 0xA5A5A5A5, `dmem_addr` = 0x1000.
- LB/LBU at 0x1002, `dmem_rdata` = 0x0080_0000 → `mem_rdata` = 0xFFFFFF80 / 0x00000080. LH at 0x1002, `dmem_rdata` = 0x8001_0000 → 0xFFFF8001.
- Load with `dmem_rvalid` delayed 4 cycles, then reset asserted in WAIT → `dmem_req` and `bus_out.valid` 0 immediately; state IDLE.
- With `MEM_MISALIGN_TRAP_EN`, LW at 0x1001 → no `dmem_req`, `misalign_fault` pulse, `bus_out.RegWrite` = 0.
